u_fetch_unit: RTL
=================

U_FETCH_UNIT -- requirements
Module: u_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 16'h0000: PC value loaded on reset.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port enable, input, 1 bit: when 1, new fetches are permitted.
REQ-005 The block SHALL have port branch_valid, input, 1 bit: redirect request.
REQ-006 The block SHALL have port branch_target, input, [0:15]: redirect address.
REQ-007 The block SHALL have port mem_address, output, [0:15]: address to the program memory; combinational copy of the PC register.
REQ-008 The block SHALL have port mem_data, input, [0:15]: word returned by the program memory, valid one cycle after its address.
REQ-009 The block SHALL have port out_valid, output, 1 bit: instruction available downstream.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-011 The block SHALL have port out_instr, output, [0:15]: fetched instruction.
REQ-012 The block SHALL have port out_pc, output, [0:15]: address out_instr was fetched from.
REQ-013 All multi-bit ports SHALL be numbered [0:15], with bit 0 as the MSB.

Function
REQ-014 The block SHALL treat the memory as a 1-cycle registered read: an address presented in cycle N yields mem_data in cycle N+1.
REQ-015 The block SHALL define stall = out_valid & ~out_ready, and issue = enable & ~stall & ~branch_valid.
REQ-016 On issue, the block SHALL advance PC to PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000) and SHALL set f_valid=1 with f_pc=PC; otherwise PC SHALL hold and f_valid SHALL be 0.
REQ-017 The block SHALL treat a word on mem_data as live only when f_valid=1.
REQ-018 The output register SHALL load when ~stall: from the skid buffer if skid_valid=1; otherwise from mem_data/f_pc if f_valid=1; otherwise out_valid SHALL go to 0.
REQ-019 When stall=1 and f_valid=1, the block SHALL capture the live word into the skid buffer (depth 1, skid_valid=1); the output register SHALL hold.
REQ-020 The skid buffer SHALL never overflow, because issue is 0 during stall; the bench SHALL flag skid_valid & f_valid & stall as an error.
REQ-021 The skid buffer SHALL drain on the first cycle with ~stall.
REQ-022 out_instr and out_pc SHALL stay stable while stall=1.
REQ-023 A handshake SHALL occur when out_valid & out_ready; every fetched word SHALL be delivered exactly once, in address order, between redirects.
REQ-024 branch_valid SHALL have priority over all other events. At the edge where it is sampled, the block SHALL load PC=branch_target and clear f_valid, skid_valid and out_valid, even during a stall.
REQ-025 Redirect latency: after branch_valid in cycle N, mem_address SHALL equal branch_target in cycle N+1, and out_valid with out_pc=branch_target SHALL appear in cycle N+3 if enable=1.
REQ-026 With enable=0, the block SHALL still deliver words already in flight (f_valid/skid) and SHALL issue no new fetches.
REQ-027 When enable=1 and stall=0 continuously, throughput SHALL be one instruction per cycle.

Reset
REQ-028 While reset_n=0 at a rising edge, the block SHALL set PC=RESET_VECTOR, f_valid=0, skid_valid=0, out_valid=0, out_instr=16'h0000 and out_pc=16'h0000.
REQ-029 Reset SHALL override branch_valid and discard any stalled or in-flight word.
REQ-030 First fetch: with reset_n released before cycle 0 and enable=1, mem_address SHALL be RESET_VECTOR in cycle 0, and out_valid with out_pc=RESET_VECTOR SHALL appear in cycle 2.

Configuration
REQ-031 When macro FETCH_PERF_COUNT_EN is defined, the block SHALL add output fetch_count, [0:15], which increments by 1 on each handshake, wraps at 16'hFFFF to 16'h0000, and resets to 16'h0000.
REQ-032 When FETCH_PERF_COUNT_EN is undefined, the fetch_count port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset scenario: memory loaded with data[i]=i, enable=1, out_ready=1 -> out_pc/out_instr SHALL be 0,1,2,3 in cycles 2,3,4,5, one per cycle.
REQ-034 Backpressure scenario: drop out_ready for 3 cycles while out_instr=2 -> out_instr SHALL hold at 2, skid SHALL capture 3, and after release the delivered sequence SHALL be 2,3,4 with no loss or duplication.
REQ-035 Redirect scenario: branch_valid with branch_target=16'h0100 while stalled and skid full -> skid and output SHALL be flushed, mem_address SHALL be 0x0100 next cycle, and out_pc=0x0100 SHALL appear 3 cycles after the request.
REQ-036 Wrap scenario: redirect to 16'hFFFE -> out_pc sequence SHALL be FFFE, FFFF, 0000.
REQ-037 Mid-operation reset scenario: reset_n=0 for 1 cycle mid-stream with RESET_VECTOR=16'h0010 -> out_valid SHALL be 0 the next cycle, and delivery SHALL restart at out_pc=0x0010.
REQ-038 Counter scenario: with FETCH_PERF_COUNT_EN defined, 5 handshakes including 2 stall cycles -> fetch_count SHALL equal 5.

Source files
------------

// File: rtl/u_fetch_unit.sv
// u_fetch_unit -- single-issue instruction fetch front end.
//
// Drives a program memory with a 1-cycle registered read. The PC register
// drives mem_address directly, and a fetch stage tracks which address is in
// flight. A one-entry skid buffer catches a returning word when the output
// register is stalled. Branch redirects flush every in-flight word.
//
// Parameters:
//   RESET_VECTOR   PC value loaded by reset.
// Ports:
//   clock          rising-edge clock for all state
//   reset_n        synchronous active-low reset (overrides branch_valid)
//   enable         permits new fetches
//   branch_valid   redirect request; takes priority over everything else
//   branch_target  redirect address
//   mem_address    program memory address (combinational copy of the PC)
//   mem_data       memory word for the address presented one cycle earlier
//   out_valid      instruction available downstream
//   out_ready      downstream accepts
//   out_instr      fetched instruction
//   out_pc         address out_instr was fetched from
//   fetch_count    handshake counter, present only when FETCH_PERF_COUNT_EN
//                  is defined
// All multi-bit ports are [0:15] with bit 0 as the MSB.
module u_fetch_unit #(
  parameter logic [0:15] RESET_VECTOR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        branch_valid,
  input  logic [0:15] branch_target,
  output logic [0:15] mem_address,
  input  logic [0:15] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:15] out_instr,
  output logic [0:15] out_pc
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [0:15] fetch_count
`endif
);

  logic [0:15] pc_reg, pc_next;
  logic        f_valid_reg, f_valid_next;
  logic [0:15] f_pc_reg, f_pc_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [0:15] skid_instr_reg, skid_instr_next;
  logic [0:15] skid_pc_reg, skid_pc_next;
  logic        out_valid_reg, out_valid_next;
  logic [0:15] out_instr_reg, out_instr_next;
  logic [0:15] out_pc_reg, out_pc_next;

  logic stall;
  logic issue;

  assign stall = out_valid_reg & ~out_ready;
  // No fetch is issued while stalled, so at most one live word can be
  // waiting when the stall starts, and one skid entry is enough.
  assign issue = enable & ~stall & ~branch_valid;

  assign mem_address = pc_reg;
  assign out_valid   = out_valid_reg;
  assign out_instr   = out_instr_reg;
  assign out_pc      = out_pc_reg;

  always_comb begin
    pc_next         = pc_reg;
    f_valid_next    = 1'b0;
    f_pc_next       = f_pc_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    out_valid_next  = out_valid_reg;
    out_instr_next  = out_instr_reg;
    out_pc_next     = out_pc_reg;

    if (branch_valid) begin
      // Redirect: the word in flight, the skid entry and the output are
      // all discarded, even when the output is stalled.
      pc_next         = branch_target;
      skid_valid_next = 1'b0;
      out_valid_next  = 1'b0;
    end else begin
      if (issue) begin
        pc_next      = pc_reg + 16'd1;
        f_valid_next = 1'b1;
        f_pc_next    = pc_reg;
      end

      if (stall) begin
        if (f_valid_reg) begin
          skid_valid_next = 1'b1;
          skid_instr_next = mem_data;
          skid_pc_next    = f_pc_reg;
        end
      end else if (skid_valid_reg) begin
        // The skid entry is older than anything fetched after it.
        out_valid_next  = 1'b1;
        out_instr_next  = skid_instr_reg;
        out_pc_next     = skid_pc_reg;
        skid_valid_next = 1'b0;
      end else if (f_valid_reg) begin
        out_valid_next = 1'b1;
        out_instr_next = mem_data;
        out_pc_next    = f_pc_reg;
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_reg         <= RESET_VECTOR;
      f_valid_reg    <= 1'b0;
      f_pc_reg       <= 16'h0000;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= 16'h0000;
      skid_pc_reg    <= 16'h0000;
      out_valid_reg  <= 1'b0;
      out_instr_reg  <= 16'h0000;
      out_pc_reg     <= 16'h0000;
    end else begin
      pc_reg         <= pc_next;
      f_valid_reg    <= f_valid_next;
      f_pc_reg       <= f_pc_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      out_valid_reg  <= out_valid_next;
      out_instr_reg  <= out_instr_next;
      out_pc_reg     <= out_pc_next;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [0:15] count_reg;

  // Counts every accepted handshake, including one coinciding with a redirect.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_reg <= 16'h0000;
    end else if (out_valid_reg & out_ready) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign fetch_count = count_reg;
`endif

endmodule
